// File: rtl/upg_pkg.sv
// upg_pkg: shared state encoding and protocol constants for the UART program loader
package upg_pkg;
    typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, DONE} upg_state_e;
    localparam logic [7:0] CMD_INST = 8'h49;
    localparam logic [7:0] CMD_DATA = 8'h44;
    localparam logic [7:0] CMD_END  = 8'h45;
    localparam logic SEL_INST = 1'b0;
    localparam logic SEL_DATA = 1'b1;
endpackage

// File: rtl/uart_prog_loader_if.sv
// uart_prog_loader_if: received-byte stream in, memory upgrade write port and status out
interface uart_prog_loader_if #(parameter int ADDR_W = 14);
    logic              Rx_vld_i;
    logic [7:0]        Rx_dat_i;
    logic              Upg_wen_o;
    logic [ADDR_W:0]   Upg_adr_o;
    logic [31:0]       Upg_dat_o;
    logic              Upg_done_o;
    logic              Upg_busy_o;
    logic              Upg_err_o;
    modport master (
        output Rx_vld_i, Rx_dat_i,
        input  Upg_wen_o, Upg_adr_o, Upg_dat_o, Upg_done_o, Upg_busy_o, Upg_err_o
    );
    modport slave (
        input  Rx_vld_i, Rx_dat_i,
        output Upg_wen_o, Upg_adr_o, Upg_dat_o, Upg_done_o, Upg_busy_o, Upg_err_o
    );
endinterface

// File: rtl/upg_timeout_cnt.sv
// upg_timeout_cnt: idle-cycle counter, cleared by clr or when disabled, pulses tc on the TIMEOUT_CYCLES-th idle cycle
module upg_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tc
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    logic [W-1:0] cnt_q, cnt_d;
    assign tc    = en && !clr && (cnt_q == W'(TIMEOUT_CYCLES - 1));
    assign cnt_d = (!en || clr || tc) ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: parses I/D/E framed byte stream into little-endian word writes for the memory upgrade port
module uart_prog_loader
    import upg_pkg::*;
#(
    parameter int ADDR_W         = 14,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              Upg_clk_i,
    input  logic              Upg_rstn_i,
    uart_prog_loader_if.slave bus
);
    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;
    upg_state_e        state_q, state_d;
    logic              sel_q, sel_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [1:0]        bidx_q, bidx_d;
    logic [23:0]       wbuf_q, wbuf_d;
    logic              wen_q, wen_d;
    logic [ADDR_W:0]   adr_q, adr_d;
    logic [31:0]       dat_q, dat_d;
    logic              done_q, done_d, busy_q, busy_d, err_q, err_d;
    logic              tmo, vld, last_word;
    logic [7:0]        rx;
    logic [15:0]       n_new;
    assign vld       = bus.Rx_vld_i;
    assign rx        = bus.Rx_dat_i;
    assign n_new     = {rx, cnt_q[7:0]};
    assign last_word = (17'(waddr_q) + 17'd1) == 17'(cnt_q);
    upg_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
        .clk   (Upg_clk_i),
        .rst_n (Upg_rstn_i),
        .en    (busy_q),
        .clr   (vld),
        .tc    (tmo)
    );
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        waddr_d = waddr_q;
        bidx_d  = bidx_q;
        wbuf_d  = wbuf_q;
        wen_d   = 1'b0;
        adr_d   = adr_q;
        dat_d   = dat_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (vld) begin
                if (rx == CMD_INST || rx == CMD_DATA) begin
                    sel_d   = (rx == CMD_DATA) ? SEL_DATA : SEL_INST;
                    state_d = CNT_LO;
                end else if (rx == CMD_END) begin
                    state_d = DONE;
                end
            end
            CNT_LO: if (vld) begin
                cnt_d[7:0] = rx;
                state_d    = CNT_HI;
            end else if (tmo) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end
            CNT_HI: if (vld) begin
                cnt_d = n_new;
                if (n_new == 16'd0) begin
                    state_d = IDLE;
                end else if (17'(n_new) > MAX_WORDS) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    waddr_d = '0;
                    bidx_d  = '0;
                    state_d = DATA;
                end
            end else if (tmo) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end
            DATA: if (vld) begin
                bidx_d = bidx_q + 2'd1;
                wbuf_d = ((bidx_q == 2'd0) ? 24'd0 : wbuf_q) | (24'(rx) << {bidx_q, 3'b000});
                // fourth byte: the strobe, address and word all register on this edge
                if (bidx_q == 2'd3) begin
                    wen_d   = 1'b1;
                    adr_d   = {sel_q, waddr_q};
                    dat_d   = {rx, wbuf_q};
                    waddr_d = waddr_q + 1'b1;
                    if (last_word) state_d = IDLE;
                end
            end else if (tmo) begin
                err_d   = 1'b1;
                bidx_d  = '0;
                state_d = IDLE;
            end
            default: ;
        endcase
        done_d = (state_d == DONE);
        busy_d = (state_d inside {CNT_LO, CNT_HI, DATA});
    end
    always_ff @(posedge Upg_clk_i or negedge Upg_rstn_i) begin
        if (!Upg_rstn_i) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            cnt_q   <= '0;
            waddr_q <= '0;
            bidx_q  <= '0;
            wbuf_q  <= '0;
            wen_q   <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            waddr_q <= waddr_d;
            bidx_q  <= bidx_d;
            wbuf_q  <= wbuf_d;
            wen_q   <= wen_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end
    assign bus.Upg_wen_o  = wen_q;
    assign bus.Upg_adr_o  = adr_q;
    assign bus.Upg_dat_o  = dat_q;
    assign bus.Upg_done_o = done_q;
    assign bus.Upg_busy_o = busy_q;
    assign bus.Upg_err_o  = err_q;
endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Upstream feeder of the instruction/data memory download port: consumes the byte stream from the UART receiver.
- Parses a framed load protocol and assembles little-endian 32-bit words.
- Drives word write strobes, addresses and data into the memory upgrade interface.
- Raises Upg_done_o after the end-of-load marker so the memories hand their ports back to the CPU.

Parameters:
- ADDR_W, 14, word-address width per memory (16384 words = 64 KB).
- TIMEOUT_CYCLES, 1_000_000, max idle clocks between bytes inside a frame before abort.

Ports:
- Upg_clk_i  in  1  clock; all logic on rising edge.
- Upg_rstn_i  in  1  reset; asynchronous, active-low.
- Rx_vld_i  in  1  one-cycle pulse per received byte; back-to-back cycles allowed.
- Rx_dat_i  in  8  received byte, valid when Rx_vld_i=1.
- Upg_wen_o  out  1  one-cycle write strobe.
- Upg_adr_o  out  ADDR_W+1  bit[ADDR_W] selects the memory (0 = instruction, 1 = data); low bits are the word address.
- Upg_dat_o  out  32  write data.
- Upg_done_o  out  1  load finished; CPU may run.
- Upg_busy_o  out  1  a frame is in progress (not IDLE/DONE).
- Upg_err_o  out  1  sticky error flag.

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0. Reset takes effect immediately at any point, including mid-frame; any partial word is discarded.
- Protocol (one frame):
  - Command byte: 0x49 'I' for instruction, 0x44 'D' for data.
  - Count, 2 bytes, little-endian: N = number of words.
  - Then N words of 4 bytes each, LSB first.
  - Any number of frames may follow. Byte 0x45 'E' in IDLE ends the load.
- States:
  - IDLE: 'I' or 'D' latches the select bit and goes to CNT_LO. 'E' goes to DONE. Any other byte is ignored and does not set the error flag.
  - CNT_LO: latch count[7:0], go to CNT_HI.
  - CNT_HI: latch count[15:8]. If N=0, go to IDLE. If N > 2^ADDR_W, set Upg_err_o and go to IDLE with no writes. Otherwise clear the word address and byte index, then go to DATA.
  - DATA: on each byte, shift it into the word buffer at position byte_idx*8 and increment the 2-bit byte_idx. When the 4th byte is accepted:
    - Next cycle, Upg_wen_o=1 for exactly one cycle.
    - In that cycle, Upg_adr_o = {sel, word_addr} and Upg_dat_o = the assembled word.
    - word_addr then increments.
    - After the Nth word, go to IDLE.
  - DONE: Upg_done_o=1 and holds until reset. All further bytes are ignored.
- Latency: 1 clock from the edge accepting the 4th byte to the Upg_wen_o cycle. A back-to-back next byte is accepted in the same cycle as that strobe, with no stall.
- Upg_adr_o and Upg_dat_o hold their last values when Upg_wen_o=0.
- Timeout:
  - A counter runs in CNT_LO, CNT_HI and DATA, clearing on every accepted byte.
  - On reaching TIMEOUT_CYCLES: set Upg_err_o, go to IDLE, discard the partial word. Words already written stay written.
  - The counter does not run in IDLE or DONE.
- Upg_err_o is cleared only by reset and does not block later frames or DONE.
- Upg_busy_o = state ∈ {CNT_LO, CNT_HI, DATA}, registered together with the state.
- Word address never wraps: the N ≤ 2^ADDR_W check guarantees the final word is at 2^ADDR_W−1.

Decomposition:
- Shared package (upg_pkg):
  - state encoding enum (IDLE, CNT_LO, CNT_HI, DATA, DONE);
  - command byte constants CMD_INST=8'h49, CMD_DATA=8'h44, CMD_END=8'h45;
  - memory select constants SEL_INST=0, SEL_DATA=1.
- One natural sub-module: upg_timeout_cnt, a loadable/clearable counter with a terminal-count pulse, parameterised by TIMEOUT_CYCLES.
- Word assembly, address counter and FSM live in the top module.

Test Plan:
- Send 49 02 00 | 78 56 34 12 | EF BE AD DE | 45 -> wen at adr 0x0000 with dat 0x12345678, then adr 0x0001 with dat 0xDEADBEEF; done=1 after 0x45; err=0.
- Frame 44 01 00 AA BB CC DD with bytes on consecutive cycles -> single wen, adr 0x4000, dat 0xDDCCBBAA, exactly 1 cycle after 4th byte; busy drops on the same edge as the state returns to IDLE.
- Send 49 01 40 (N=16385) -> no wen, err=1, state IDLE. Then 49 01 00 11 22 33 44 45 -> write adr 0 dat 0x44332211; done=1; err remains 1.
- Send 49 01 00 11 22, then idle TIMEOUT_CYCLES (bench uses 16) -> err=1, no wen, busy=0. A following 'I' frame loads normally from adr 0.
- Pull Upg_rstn_i low asynchronously mid-word (after 2 data bytes) -> all outputs 0 immediately. After release, a full frame writes correctly from adr 0.
- Bytes 00 7F 45 in IDLE, then 49 in DONE -> 00/7F ignored with err=0; done=1; the 49 in DONE produces no busy and no wen.
